// File: rtl/dsc_mul_ctrl.sv
// dsc_mul_ctrl: sequences one dsc_mul multiplication per accepted operand triple and returns the product
module dsc_mul_ctrl #(
  parameter int SNG_WIDTH  = 6,
  parameter int NUM_INPUTS = 3,
  parameter int PW         = NUM_INPUTS * SNG_WIDTH,
  parameter int TIMEOUT    = 2 ** PW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] in_a,
  input  logic [SNG_WIDTH-1:0] in_b,
  input  logic [SNG_WIDTH-1:0] in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_z,
  output logic [PW:0]          out_cycles,
  output logic                 out_err,
  output logic                 busy,
  output logic [SNG_WIDTH-1:0] mul_a,
  output logic [SNG_WIDTH-1:0] mul_b,
  output logic [SNG_WIDTH-1:0] mul_c,
  output logic                 mul_rst,
  output logic                 mul_en,
  input  logic [PW-1:0]        mul_z,
  input  logic                 mul_ov
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, DONE} state_t;
  localparam logic [PW:0] TO = (PW+1)'(TIMEOUT);
  state_t               state_q, state_d;
  logic [SNG_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [PW-1:0]        z_q, z_d;
  logic [PW:0]          cyc_q, cyc_d, cnt_q, cnt_d, cnt_inc;
  logic                 err_q, err_d, flag_q, flag_d;
  assign cnt_inc    = (cnt_q == TO) ? cnt_q : cnt_q + 1'b1;
  assign in_ready   = !rst && state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign mul_en     = state_q == RUN;
  assign mul_rst    = rst || state_q == CLEAR;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_c      = c_q;
  assign out_z      = z_q;
  assign out_cycles = cyc_q;
  assign out_err    = err_q;
  // next-state and datapath: ov beats timeout when both land in the same RUN cycle
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    z_d = z_q;
    cyc_d = cyc_q;
    err_d = err_q;
    cnt_d = cnt_q;
    flag_d = flag_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = in_a;
        b_d = in_b;
        c_d = in_c;
        if (in_a == '0 || in_b == '0 || in_c == '0) begin
          z_d = '0;
          cyc_d = '0;
          err_d = 1'b0;
          state_d = DONE;
        end else state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = '0;
        flag_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (mul_ov) state_d = SETTLE;
        else if (cnt_inc == TO) begin
          flag_d = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        z_d = mul_z;
        cyc_d = cnt_q;
        err_d = flag_q;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      z_q <= '0;
      cyc_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      z_q <= z_d;
      cyc_q <= cyc_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      flag_q <= flag_d;
    end
  end
endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// tb_dsc_mul_ctrl: table-driven check of dsc_mul_ctrl against a latency-programmable multiplier model
module tb_dsc_mul_ctrl;
  localparam int TO = 200;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_err, busy, mul_rst, mul_en, mul_ov;
  logic [5:0]  in_a = 0, in_b = 0, in_c = 0, mul_a, mul_b, mul_c;
  logic [17:0] out_z, mul_z;
  logic [18:0] out_cycles;
  int          total = 0, bad = 0, overlap = 0, lat = 0;
  bit          ov_off = 0;
  logic [18:0] mcnt = 0;
  logic [17:0] mz = 0;
  always #5 clk = ~clk;
  dsc_mul_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cycles(out_cycles), .out_err(out_err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_z(mul_z), .mul_ov(mul_ov)
  );
  // multiplier model: ov in the lat-th enabled cycle, product visible from the following cycle
  always @(posedge clk)
    if (mul_rst) begin
      mcnt <= 0;
      mz <= 0;
    end else if (mul_en) begin
      mcnt <= mcnt + 1;
      if (int'(mcnt) + 1 == lat) mz <= 18'(mul_a) * 18'(mul_b) * 18'(mul_c);
    end
  assign mul_ov = !ov_off && int'(mcnt) == lat - 1;
  assign mul_z  = mz;
  always @(negedge clk) if (in_ready && out_valid) overlap++;

  typedef struct {int a, b, c, lat; bit off; int hold; int z, cyc; bit err;} vec_t;
  vec_t v[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic txn(input vec_t t);
    int j = 0, en_n = 0, rst_n = 0, exp_j;
    bit zero = t.a == 0 || t.b == 0 || t.c == 0;
    bit stable = 1;
    @(negedge clk);
    lat = t.lat;
    ov_off = t.off;
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1;
    in_a = 6'(t.a);
    in_b = 6'(t.b);
    in_c = 6'(t.c);
    @(posedge clk);
    #1 in_valid = 0;
    while (j < 1000) begin
      @(negedge clk);
      j++;
      en_n += int'(mul_en);
      rst_n += int'(mul_rst);
      if (out_valid) break;
    end
    exp_j = zero ? 1 : 3 + t.cyc;
    chk("latency", 32'(j), 32'(exp_j));
    chk("en_cycles", 32'(en_n), zero ? 0 : 32'(t.cyc));
    chk("rst_pulses", 32'(rst_n), zero ? 0 : 1);
    chk("mul_a", 32'(mul_a), 32'(t.a));
    chk("out_z", 32'(out_z), 32'(t.z));
    chk("out_cycles", 32'(out_cycles), 32'(t.cyc));
    chk("out_err", 32'(out_err), 32'(t.err));
    if (t.hold > 0) begin
      in_valid = 1;
      in_a = 9;
      in_b = 9;
      in_c = 9;
      repeat (t.hold) begin
        @(negedge clk);
        if (out_z !== 18'(t.z) || out_cycles !== 19'(t.cyc) || out_err !== t.err || in_ready || !out_valid) stable = 0;
      end
      chk("hold_stable", 32'(stable), 1);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    in_valid = 0;
    @(negedge clk);
    chk("in_ready_after", 32'(in_ready), 1);
    chk("valid_dropped", 32'(out_valid), 0);
    chk("not_accepted", 32'(mul_a), 32'(t.a));
  endtask

  initial begin
    int n = 0;
    v[0] = '{3, 5, 7, 10, 0, 0, 105, 10, 0};
    v[1] = '{0, 63, 63, 5, 0, 0, 0, 0, 0};
    v[2] = '{63, 63, 63, 40, 0, 10, 250047, 40, 0};
    v[3] = '{2, 3, 4, 1, 0, 0, 24, 1, 0};
    v[4] = '{1, 1, 1, 200, 0, 0, 1, 200, 0};
    v[5] = '{1, 1, 1, 0, 1, 0, 0, 200, 1};
    v[6] = '{5, 5, 5, 201, 0, 0, 0, 200, 1};
    v[7] = '{10, 20, 30, 17, 0, 3, 6000, 17, 0};
    v[8] = '{63, 0, 1, 5, 0, 0, 0, 0, 0};
    v[9] = '{7, 7, 7, 18, 0, 0, 343, 18, 0};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mul_rst", 32'(mul_rst), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_en", 32'(mul_en), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_out_z", 32'(out_z), 0);
    chk("rst_out_cycles", 32'(out_cycles), 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_mul_rst", 32'(mul_rst), 0);
    foreach (v[i]) txn(v[i]);
    @(negedge clk);
    lat = 100;
    ov_off = 0;
    in_valid = 1;
    in_a = 3;
    in_b = 3;
    in_c = 3;
    @(posedge clk);
    #1 in_valid = 0;
    for (int k = 0; k < 300 && n < 50; k++) begin
      @(negedge clk);
      n += int'(mul_en);
    end
    chk("mid_run_reached", 32'(n), 50);
    rst = 1;
    #1 chk("mid_rst_mul_rst", 32'(mul_rst), 1);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_mul_en", 32'(mul_en), 0);
    txn('{2, 2, 2, 5, 0, 0, 8, 5, 0});
    chk("no_overlap", 32'(overlap), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
